// File: rtl/booth_mult_seq.sv
// ---------------------------------------------------------------------------
// booth_mult_seq
//   Iterative radix-4 Booth multiplier. One Booth group is retired per clock
//   into a single shared adder and accumulator, so a WIDTH x WIDTH multiply
//   takes NGRP = WIDTH/2+1 cycles. The extra group lets unsigned and mixed
//   operand modes share the signed recoding path.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands valid
//   in_ready   block can accept operands (high only in IDLE)
//   x          multiplier operand, Booth-recoded
//   y          multiplicand operand
//   x_signed   1: x is two's complement, 0: unsigned
//   y_signed   1: y is two's complement, 0: unsigned
//   acc_clr    (only with BOOTH_MULT_MAC_EN) 1: start from 0,
//              0: start from the previously delivered product
//   out_valid  product valid
//   out_ready  consumer accepts product
//   product    registered result, PW = 2*WIDTH bits
//   busy       high in CALC or DONE
//
// Build option
//   BOOTH_MULT_MAC_EN  turns the block into a multiply-accumulate unit:
//                      product = previous product + x*y (mod 2^PW).
// ---------------------------------------------------------------------------
module booth_mult_seq #(
    parameter  int WIDTH = 16,
    localparam int NGRP  = WIDTH / 2 + 1,
    localparam int PW    = 2 * WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             x_signed,
    input  logic             y_signed,
`ifdef BOOTH_MULT_MAC_EN
    input  logic             acc_clr,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PW-1:0]    product,
    output logic             busy
);

    localparam int CW = $clog2(NGRP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Multiplier is consumed two bits per cycle from the bottom; xlow_reg
    // holds the bit just shifted out (xe[2k-1]), zero for the first group.
    logic [WIDTH+1:0] xs_reg;
    logic             xlow_reg;
    // Multiplicand pre-shifted by 2k so no variable shifter is needed.
    logic [PW-1:0]    ys_reg;
    logic [PW-1:0]    acc_reg;
    logic [PW-1:0]    product_reg;
    logic [CW-1:0]    cnt_reg;
    logic             out_valid_reg;

    logic [WIDTH+1:0] x_ext;
    logic [PW-1:0]    y_ext;
    logic [2:0]       trip;
    logic             sel_zero;
    logic             sel_two;
    logic             sel_neg;
    logic [PW-1:0]    mag;
    logic [PW-1:0]    addend;
    logic [PW-1:0]    acc_sum;
    logic             last_grp;
    logic [PW-1:0]    acc_start;

    assign x_ext = {{2{x_signed & x[WIDTH-1]}}, x};
    assign y_ext = {{WIDTH{y_signed & y[WIDTH-1]}}, y};

`ifdef BOOTH_MULT_MAC_EN
    assign acc_start = acc_clr ? '0 : product_reg;
`else
    assign acc_start = '0;
`endif

    // Radix-4 Booth recoding of {xe[2k+1], xe[2k], xe[2k-1]}
    assign trip = {xs_reg[1:0], xlow_reg};

    always_comb begin
        sel_zero = 1'b0;
        sel_two  = 1'b0;
        sel_neg  = 1'b0;
        case (trip)
            3'b000, 3'b111: sel_zero = 1'b1;
            3'b001, 3'b010: ;
            3'b011:         sel_two  = 1'b1;
            3'b100: begin
                sel_two = 1'b1;
                sel_neg = 1'b1;
            end
            default:        sel_neg  = 1'b1;   // 101, 110 -> -1
        endcase
    end

    assign mag      = sel_zero ? '0 : (sel_two ? (ys_reg << 1) : ys_reg);
    // Negation as invert plus carry-in folded into the single adder
    assign addend   = sel_neg ? ~mag : mag;
    assign acc_sum  = acc_reg + addend + PW'(sel_neg);
    assign last_grp = (cnt_reg == CW'(NGRP - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid) state_next = CALC;
            CALC:    if (last_grp) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xs_reg        <= '0;
            xlow_reg      <= 1'b0;
            ys_reg        <= '0;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            product_reg   <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        xs_reg   <= x_ext;
                        xlow_reg <= 1'b0;
                        ys_reg   <= y_ext;
                        acc_reg  <= acc_start;
                        cnt_reg  <= '0;
                    end
                end
                CALC: begin
                    acc_reg  <= acc_sum;
                    xs_reg   <= xs_reg >> 2;
                    xlow_reg <= xs_reg[1];
                    ys_reg   <= ys_reg << 2;
                    cnt_reg  <= cnt_reg + CW'(1);
                    if (last_grp) begin
                        product_reg   <= acc_sum;
                        out_valid_reg <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign out_valid = out_valid_reg;
    assign product   = product_reg;

endmodule

// File: tb/tb_booth_mult_seq.sv
// ---------------------------------------------------------------------------
// tb_booth_mult_seq
//   Self-checking bench for booth_mult_seq (WIDTH=16). Expected products are
//   computed with plain integer multiplication of the mode-interpreted
//   operands. Directed corner cases, backpressure, mid-operation reset and a
//   batch of random operations. MAC checks are built only when
//   BOOTH_MULT_MAC_EN is defined.
// ---------------------------------------------------------------------------
module tb_booth_mult_seq;

    localparam int W  = 16;
    localparam int PW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic          x_signed;
    logic          y_signed;
    logic          acc_clr;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] product;
    logic          busy;

    int            checks = 0;
    int            errors = 0;
    logic [PW-1:0] run_val = '0;   // last delivered product, for MAC mode

    always #5 clk = ~clk;

    booth_mult_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .x_signed  (x_signed),
        .y_signed  (y_signed),
`ifdef BOOTH_MULT_MAC_EN
        .acc_clr   (acc_clr),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic as, input logic bs, input logic clr);
        longint        av;
        longint        bv;
        logic [PW-1:0] p;
        av = as ? longint'($signed(a)) : longint'(a);
        bv = bs ? longint'($signed(b)) : longint'(b);
        p  = PW'(av * bv);
`ifdef BOOTH_MULT_MAC_EN
        if (!clr) p = p + run_val;
`endif
        return p;
    endfunction

    // Issue one operation, wait for the result and leave the DUT in DONE.
    task automatic issue_wait(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic as, input logic bs, input logic clr);
        logic [PW-1:0] exp;
        int            n;
        exp = model(a, b, as, bs, clr);
        @(negedge clk);
        check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
        in_valid = 1'b1; x = a; y = b; x_signed = as; y_signed = bs; acc_clr = clr;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(9));
        check({tag, "_product"}, 64'(product), 64'(exp));
        $display("op %s: x=%h(%0d) y=%h(%0d) clr=%0d -> product=%h expected=%h lat=%0d",
                 tag, a, as, b, bs, clr, product, exp, n);
        run_val = exp;
    endtask

    task automatic release_out(input string tag);
        logic [PW-1:0] held;
        held = product;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_ov_clr"}, 64'(out_valid), 64'(0));
        check({tag, "_idle"}, 64'(in_ready), 64'(1));
        check({tag, "_prod_kept"}, 64'(product), 64'(held));
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic as, input logic bs, input logic clr);
        issue_wait(tag, a, b, as, bs, clr);
        release_out(tag);
    endtask

    initial begin
        logic [PW-1:0] held;
        rst_n = 1'b0; in_valid = 1'b0; x = '0; y = '0;
        x_signed = 1'b0; y_signed = 1'b0; acc_clr = 1'b1; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_product", 64'(product), 64'(0));
        rst_n = 1'b1;

        // Directed corner cases (constant expectations cross-check the model)
        run_op("u_ffff", 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1);
        check("u_ffff_const", 64'(product), 64'h0000_0000_FFFE_0001);
        run_op("s_8000", 16'h8000, 16'h8000, 1'b1, 1'b1, 1'b1);
        check("s_8000_const", 64'(product), 64'h0000_0000_4000_0000);
        run_op("s_ffff", 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b1);
        check("s_ffff_const", 64'(product), 64'h0000_0000_0000_0001);
        run_op("s_7fff", 16'h7FFF, 16'h8000, 1'b1, 1'b1, 1'b1);
        check("s_7fff_const", 64'(product), 64'h0000_0000_C000_8000);
        run_op("m_su", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1);
        check("m_su_const", 64'(product), 64'h0000_0000_FFFF_0001);
        run_op("m_us", 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b1);
        check("m_us_const", 64'(product), 64'h0000_0000_FFFF_0001);

        // Backpressure: result held, new operands ignored
        issue_wait("bp", 16'h1234, 16'h5678, 1'b0, 1'b0, 1'b1);
        held = product;
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            x = W'($urandom); y = W'($urandom);
            @(negedge clk);
            check("bp_out_valid", 64'(out_valid), 64'(1));
            check("bp_product", 64'(product), 64'(held));
            check("bp_in_ready", 64'(in_ready), 64'(0));
        end
        in_valid = 1'b0;
        release_out("bp");
        run_op("bp_next", 16'h00FF, 16'h0101, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of CALC
        @(negedge clk);
        in_valid = 1'b1; x = 16'd3; y = 16'd5; x_signed = 1'b0; y_signed = 1'b0; acc_clr = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_busy_pre", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1;
        check("mid_rst_product", 64'(product), 64'(0));
        check("mid_rst_out_valid", 64'(out_valid), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_in_ready", 64'(in_ready), 64'(1));
        run_val = '0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_rst", 16'd7, 16'd6, 1'b0, 1'b0, 1'b1);
        check("after_rst_const", 64'(product), 64'h2A);

`ifdef BOOTH_MULT_MAC_EN
        run_op("mac1", 16'd3, 16'd4, 1'b0, 1'b0, 1'b1);
        check("mac1_const", 64'(product), 64'd12);
        run_op("mac2", 16'd5, 16'd6, 1'b0, 1'b0, 1'b0);
        check("mac2_const", 64'(product), 64'd42);
        run_op("mac3", 16'hFFFF, 16'h0001, 1'b1, 1'b1, 1'b0);
        check("mac3_const", 64'(product), 64'd41);
`endif

        // Random operations in all modes
        for (int i = 0; i < 40; i++) begin
            run_op("rand", W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
